// File: rtl/sram_port_arbiter.sv
// Two-master arbiter for the shared sram: independent read/write channels, write-wins collisions, rvalid routing.
// Optional build macro: SRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed m0 priority.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module sram_port_arbiter #(
    parameter int BUS_W  = `BUS_WIDTH,
    parameter int DATA_W = `DATA_WIDTH,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_ram_ren,
    input  logic [BUS_W-1:0]  m0_ram_raddr,
    output logic              m0_ram_rgnt,
    output logic              m0_ram_rvalid,
    output logic [DATA_W-1:0] m0_ram_rdata,
    input  logic [STRB_W-1:0] m0_ram_wen,
    input  logic [BUS_W-1:0]  m0_ram_waddr,
    input  logic [DATA_W-1:0] m0_ram_wdata,
    output logic              m0_ram_wgnt,
    input  logic              m1_ram_ren,
    input  logic [BUS_W-1:0]  m1_ram_raddr,
    output logic              m1_ram_rgnt,
    output logic              m1_ram_rvalid,
    output logic [DATA_W-1:0] m1_ram_rdata,
    input  logic [STRB_W-1:0] m1_ram_wen,
    input  logic [BUS_W-1:0]  m1_ram_waddr,
    input  logic [DATA_W-1:0] m1_ram_wdata,
    output logic              m1_ram_wgnt,
    output logic              s_ram_ren,
    output logic [BUS_W-1:0]  s_ram_raddr,
    output logic [STRB_W-1:0] s_ram_wen,
    output logic [BUS_W-1:0]  s_ram_waddr,
    output logic [DATA_W-1:0] s_ram_wdata,
    input  logic [DATA_W-1:0] s_ram_rdata
);

    logic             wr_req0, wr_req1;
    logic             rd_sel, wr_sel;
    logic             rd_go, wr_go, collision;
    logic [BUS_W-1:0] win_raddr, win_waddr;
    logic             rd_pend_reg, rd_id_reg;

    assign wr_req0 = |m0_ram_wen;
    assign wr_req1 = |m1_ram_wen;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic rd_last_reg, wr_last_reg;

    // On contention the master that did not win last time goes first.
    assign rd_sel = m1_ram_ren & (~m0_ram_ren | ~rd_last_reg);
    assign wr_sel = wr_req1 & (~wr_req0 | ~wr_last_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_last_reg <= 1'b1;
            wr_last_reg <= 1'b1;
        end else begin
            if (rd_go) rd_last_reg <= rd_sel;
            if (wr_go) wr_last_reg <= wr_sel;
        end
    end
`else
    assign rd_sel = m1_ram_ren & ~m0_ram_ren;
    assign wr_sel = wr_req1 & ~wr_req0;
`endif

    assign win_raddr = rd_sel ? m1_ram_raddr : m0_ram_raddr;
    assign win_waddr = wr_sel ? m1_ram_waddr : m0_ram_waddr;

    // A read of the word being written is held off one cycle so it observes the new data.
    assign wr_go     = (wr_req0 | wr_req1) & ~reset;
    assign collision = wr_go & (win_raddr[BUS_W-1:2] == win_waddr[BUS_W-1:2]);
    assign rd_go     = (m0_ram_ren | m1_ram_ren) & ~reset & ~collision;

    assign m0_ram_rgnt = rd_go & ~rd_sel;
    assign m1_ram_rgnt = rd_go & rd_sel;
    assign m0_ram_wgnt = wr_go & ~wr_sel;
    assign m1_ram_wgnt = wr_go & wr_sel;

    assign s_ram_ren   = rd_go;
    assign s_ram_raddr = m1_ram_rgnt ? m1_ram_raddr : m0_ram_raddr;
    assign s_ram_wen   = m1_ram_wgnt ? m1_ram_wen : (m0_ram_wgnt ? m0_ram_wen : '0);
    assign s_ram_waddr = m1_ram_wgnt ? m1_ram_waddr : m0_ram_waddr;
    assign s_ram_wdata = m1_ram_wgnt ? m1_ram_wdata : m0_ram_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_reg <= 1'b0;
            rd_id_reg   <= 1'b0;
        end else begin
            rd_pend_reg <= rd_go;
            rd_id_reg   <= rd_sel;
        end
    end

    // Gated by reset so a read granted just before reset never reports valid.
    assign m0_ram_rvalid = rd_pend_reg & ~reset & ~rd_id_reg;
    assign m1_ram_rvalid = rd_pend_reg & ~reset & rd_id_reg;
    assign m0_ram_rdata  = s_ram_rdata;
    assign m1_ram_rdata  = s_ram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: sram model plus a word-level reference of grants, ownership and data.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ren;
    logic [31:0] raddr [2];
    logic [3:0]  wen [2];
    logic [31:0] waddr [2];
    logic [31:0] wdata [2];
    logic [1:0]  rgnt, wgnt, rvalid;
    logic [31:0] rdata [2];
    logic        s_ram_ren;
    logic [31:0] s_ram_raddr, s_ram_waddr, s_ram_wdata;
    logic [3:0]  s_ram_wen;
    logic [31:0] s_ram_rdata;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_ram_ren(ren[0]), .m0_ram_raddr(raddr[0]), .m0_ram_rgnt(rgnt[0]),
        .m0_ram_rvalid(rvalid[0]), .m0_ram_rdata(rdata[0]),
        .m0_ram_wen(wen[0]), .m0_ram_waddr(waddr[0]), .m0_ram_wdata(wdata[0]),
        .m0_ram_wgnt(wgnt[0]),
        .m1_ram_ren(ren[1]), .m1_ram_raddr(raddr[1]), .m1_ram_rgnt(rgnt[1]),
        .m1_ram_rvalid(rvalid[1]), .m1_ram_rdata(rdata[1]),
        .m1_ram_wen(wen[1]), .m1_ram_waddr(waddr[1]), .m1_ram_wdata(wdata[1]),
        .m1_ram_wgnt(wgnt[1]),
        .s_ram_ren(s_ram_ren), .s_ram_raddr(s_ram_raddr), .s_ram_wen(s_ram_wen),
        .s_ram_waddr(s_ram_waddr), .s_ram_wdata(s_ram_wdata), .s_ram_rdata(s_ram_rdata)
    );

    // Environment: 8-word sram with registered read and byte-strobed write.
    logic [31:0] sram_mem [8];
    always @(posedge clk) begin
        if (s_ram_ren) s_ram_rdata <= sram_mem[s_ram_raddr[4:2]];
        for (int b = 0; b < 4; b++)
            if (s_ram_wen[b]) sram_mem[s_ram_waddr[4:2]][b*8 +: 8] <= s_ram_wdata[b*8 +: 8];
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference state
    logic [31:0] ref_mem [8];
    bit          last_r, last_w;
    bit          pend, owner;
    logic [31:0] pend_data;

    function automatic bit pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            return !last;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    task automatic new_request(input int n);
        if (!ren[n] && $urandom_range(0, 1) == 1) begin
            ren[n]   = 1'b1;
            raddr[n] = $urandom_range(0, 31);
        end
        if (wen[n] == 4'h0 && $urandom_range(0, 1) == 1) begin
            wen[n]   = 4'($urandom_range(1, 15));
            waddr[n] = $urandom_range(0, 31);
            wdata[n] = $urandom;
        end
    endtask

    initial begin
        bit          rsel, wsel, rreq, wreq, coll, rgo, wgo;
        logic [31:0] ra, wa;
        logic [3:0]  exp_swen;
        int          rst_left;

        for (int i = 0; i < 8; i++) begin
            sram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        last_r = 1'b1; last_w = 1'b1; pend = 1'b0; owner = 1'b0; pend_data = '0;
        // Both masters requesting while reset is held.
        reset = 1'b1;
        rst_left = 3;
        for (int n = 0; n < 2; n++) begin
            ren[n] = 1'b1; raddr[n] = 32'h4 * (n + 1);
            wen[n] = 4'hF; waddr[n] = 32'h10 + 32'h4 * n; wdata[n] = $urandom;
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rreq = ren[0] | ren[1];
            wreq = (wen[0] != 0) | (wen[1] != 0);
            rsel = pick(ren[0], ren[1], last_r);
            wsel = pick(wen[0] != 0, wen[1] != 0, last_w);
            ra   = raddr[rsel];
            wa   = waddr[wsel];
            wgo  = wreq && !reset;
            coll = wgo && rreq && (ra[31:2] == wa[31:2]);
            rgo  = rreq && !reset && !coll;
            exp_swen = wgo ? wen[wsel] : 4'h0;

            check_eq("m0_rgnt", rgnt[0], rgo && !rsel);
            check_eq("m1_rgnt", rgnt[1], rgo && rsel);
            check_eq("m0_wgnt", wgnt[0], wgo && !wsel);
            check_eq("m1_wgnt", wgnt[1], wgo && wsel);
            check_eq("s_ren", s_ram_ren, rgo);
            check_eq("s_wen", s_ram_wen, exp_swen);
            check_eq("m0_rvalid", rvalid[0], pend && !reset && !owner);
            check_eq("m1_rvalid", rvalid[1], pend && !reset && owner);
            if (pend && !reset) check_eq(owner ? "m1_rdata" : "m0_rdata", rdata[owner], pend_data);
            if (rgo) check_eq("s_raddr", s_ram_raddr, ra);
            if (wgo) begin
                check_eq("s_waddr", s_ram_waddr, wa);
                check_eq("s_wdata", s_ram_wdata, wdata[wsel]);
            end
            $display("cyc=%0d rst=%0b ren=%b wen0=%h wen1=%h rg=%b wg=%b rv=%b coll=%0b",
                     cyc, reset, ren, wen[0], wen[1], rgnt, wgnt, rvalid, coll);

            @(posedge clk);
            if (reset) begin
                pend = 1'b0; owner = 1'b0; last_r = 1'b1; last_w = 1'b1;
            end else begin
                pend      = rgo;
                owner     = rsel;
                pend_data = ref_mem[ra[4:2]];
                if (rgo) last_r = rsel;
                if (wgo) begin
                    last_w = wsel;
                    for (int b = 0; b < 4; b++)
                        if (wen[wsel][b]) ref_mem[wa[4:2]][b*8 +: 8] = wdata[wsel][b*8 +: 8];
                end
            end
            #1;
            if (rgo) ren[rsel] = 1'b0;
            if (wgo) wen[wsel] = 4'h0;
            if (rst_left > 0) rst_left--;
            if (rst_left == 0 && cyc > 5 && $urandom_range(0, 39) == 0)
                rst_left = $urandom_range(1, 2);
            reset = (rst_left > 0);
            for (int n = 0; n < 2; n++) new_request(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
